alu_operand_sequencer: RTL and testbench

Front-end stage that sits directly upstream of the 4-bit ALU. It turns raw pushbutton presses into operand A, operand B, a 3-bit op select and a carry-in. It then fires the ALU for exactly one cycle and latches the result and flags for display logic.
It is an operand-entry state machine with synchronizers, edge detection and result capture.

---
 rtl/alu_operand_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// Operand-entry front end for the 4-bit ALU: pushbutton sync, edge detect,
// entry FSM, one-cycle ALU fire and result capture.
//
// Ports:
//   hz100      system clock
//   reset      asynchronous active-low reset
//   pb[19:0]   raw buttons: [15:0] digits, [16] cin toggle, [17] enter,
//              [18] clear, [19] unused
//   alu_a/b    operand registers to the ALU
//   alu_ctrl   op select register
//   alu_cin    carry-in register
//   alu_en     ALU enable, high only in EXEC
//   alu_m/s/o/cout  ALU result and flags
//   res_m      captured result
//   res_flags  captured {S,O,Cout}
//   res_valid  high while a captured result is shown
//   state      current FSM state encoding
module alu_operand_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        hz100,
  input  logic        reset,
  input  logic [19:0] pb,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [2:0]  alu_ctrl,
  output logic        alu_cin,
  output logic        alu_en,
  input  logic [3:0]  alu_m,
  input  logic        alu_s,
  input  logic        alu_o,
  input  logic        alu_cout,
  output logic [3:0]  res_m,
  output logic [2:0]  res_flags,
  output logic        res_valid,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    SHOW   = 3'd4
  } state_t;

  localparam int WARM = SYNC_STAGES + 1;
  localparam int WW   = $clog2(WARM + 1);
  localparam logic [WW-1:0] WARM_V = WW'(WARM);

  state_t      r_state;
  logic [18:0] r_sync [SYNC_STAGES];
  logic [18:0] r_prev;
  logic [WW-1:0] r_warm;

  logic [18:0] w_synced;
  logic [18:0] w_evt;
  logic        w_live;
  logic        w_clr;
  logic        w_ent;
  logic        w_tog;
  logic        w_dig_any;
  logic [3:0]  w_dig;
  logic        w_unused;

  assign w_unused = &{1'b0, pb[19]};

  // Synchronizer chain and per-bit edge history.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_sync[0] <= pb[18:0];
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= w_synced;
    end
  end

  // The sync chain restarts from zero after reset, so a button held
  // through reset would look like a fresh press once it refills.
  // Events stay masked until the history has caught up with the chain.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      r_warm <= '0;
    end else if (r_warm != WARM_V) begin
      r_warm <= r_warm + 1'b1;
    end
  end

  assign w_live   = (r_warm == WARM_V);
  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_evt    = w_synced & ~r_prev & {19{w_live}};

  // Priority: clear > enter > cin toggle > lowest digit.
  assign w_clr = w_evt[18];
  assign w_ent = w_evt[17] & ~w_evt[18];
  assign w_tog = w_evt[16] & ~w_evt[17] & ~w_evt[18];
  assign w_dig_any = (|w_evt[15:0]) & ~(|w_evt[18:16]);

  always_comb begin
    w_dig = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (w_evt[i]) begin
        w_dig = 4'(i);
      end
    end
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      r_state   <= GET_A;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= '0;
      alu_cin   <= 1'b0;
      res_m     <= '0;
      res_flags <= '0;
    end else if (w_clr) begin
      r_state   <= GET_A;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= '0;
      alu_cin   <= 1'b0;
      res_m     <= '0;
      res_flags <= '0;
    end else begin
      case (r_state)
        GET_A: begin
          if (w_ent) begin
            r_state <= GET_B;
          end else if (w_tog) begin
            alu_cin <= ~alu_cin;
          end else if (w_dig_any) begin
            alu_a <= w_dig;
          end
        end
        GET_B: begin
          if (w_ent) begin
            r_state <= GET_OP;
          end else if (w_tog) begin
            alu_cin <= ~alu_cin;
          end else if (w_dig_any) begin
            alu_b <= w_dig;
          end
        end
        GET_OP: begin
          if (w_ent) begin
            r_state <= EXEC;
          end else if (w_tog) begin
            alu_cin <= ~alu_cin;
          end else if (w_dig_any && !w_dig[3]) begin
            alu_ctrl <= w_dig[2:0];
          end
        end
        EXEC: begin
          res_m     <= alu_m;
          res_flags <= {alu_s, alu_o, alu_cout};
          r_state   <= SHOW;
        end
        SHOW: begin
          if (w_ent) begin
            r_state <= GET_A;
          end
        end
        default: begin
          r_state <= GET_A;
        end
      endcase
    end
  end

  // Pure state decodes so an async reset drops them immediately.
  assign alu_en    = (r_state == EXEC);
  assign res_valid = (r_state == SHOW);
  assign state     = r_state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a small external ALU
// model; table of operand vectors plus hand-built corner sequences.
module tb_alu_operand_sequencer;

  logic        hz100;
  logic        reset;
  logic [19:0] pb;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [2:0]  alu_ctrl;
  logic        alu_cin;
  logic        alu_en;
  logic [3:0]  alu_m;
  logic        alu_s;
  logic        alu_o;
  logic        alu_cout;
  logic [3:0]  res_m;
  logic [2:0]  res_flags;
  logic        res_valid;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;
  int en_cnt = 0;
  bit saw_op = 0;

  alu_operand_sequencer #(.SYNC_STAGES(2)) dut (
    .hz100(hz100), .reset(reset), .pb(pb),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_cin(alu_cin), .alu_en(alu_en),
    .alu_m(alu_m), .alu_s(alu_s), .alu_o(alu_o),
    .alu_cout(alu_cout),
    .res_m(res_m), .res_flags(res_flags),
    .res_valid(res_valid), .state(state)
  );

  initial hz100 = 0;
  always #5 hz100 = ~hz100;

  // ALU model: 0 add, 1 xor, 6 a&~b, others or.
  always_comb begin
    logic [4:0] sum;
    sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
    alu_o = 1'b0;
    alu_cout = 1'b0;
    case (alu_ctrl)
      3'd0: begin
        alu_m = sum[3:0];
        alu_cout = sum[4];
        alu_o = (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);
      end
      3'd1: alu_m = alu_a ^ alu_b;
      3'd6: alu_m = alu_a & ~alu_b;
      default: alu_m = alu_a | alu_b;
    endcase
    alu_s = alu_m[3];
  end

  always @(negedge hz100) begin
    if (alu_en) en_cnt++;
    if (state == 3'd2) saw_op = 1;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input int b);
    @(negedge hz100);
    pb[b] = 1'b1;
    repeat (4) @(negedge hz100);
    pb[b] = 1'b0;
    repeat (4) @(negedge hz100);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic       cin;
    logic [3:0] m;
    logic [2:0] f;
  } vec_t;

  vec_t v[6];

  initial begin
    v[0] = '{4'h5, 4'h3, 3'd0, 1'b0, 4'h8, 3'b110};
    v[1] = '{4'hA, 4'h3, 3'd6, 1'b0, 4'h8, 3'b100};
    v[2] = '{4'h7, 4'h1, 3'd0, 1'b1, 4'h9, 3'b110};
    v[3] = '{4'hF, 4'h1, 3'd0, 1'b0, 4'h0, 3'b001};
    v[4] = '{4'h8, 4'h8, 3'd0, 1'b0, 4'h0, 3'b011};
    v[5] = '{4'hC, 4'hA, 3'd1, 1'b0, 4'h6, 3'b000};

    pb = '0;
    reset = 0;
    repeat (3) @(negedge hz100);
    chk("rst_state", 32'(state), 0);
    chk("rst_a", 32'(alu_a), 0);
    chk("rst_en", 32'(alu_en), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_res", 32'({res_m, res_flags}), 0);
    reset = 1;
    repeat (6) @(negedge hz100);
    chk("post_rst_state", 32'(state), 0);

    for (int i = 0; i < 6; i++) begin
      press(18);
      press(int'(v[i].a));
      press(17);
      press(int'(v[i].b));
      press(17);
      if (v[i].cin) press(16);
      press(9);
      press(int'(v[i].op));
      chk($sformatf("v%0d_ctrl", i), 32'(alu_ctrl), 32'(v[i].op));
      chk($sformatf("v%0d_cin", i), 32'(alu_cin), 32'(v[i].cin));
      en_cnt = 0;
      press(17);
      chk($sformatf("v%0d_state", i), 32'(state), 4);
      chk($sformatf("v%0d_valid", i), 32'(res_valid), 1);
      chk($sformatf("v%0d_m", i), 32'(res_m), 32'(v[i].m));
      chk($sformatf("v%0d_f", i), 32'(res_flags), 32'(v[i].f));
      chk($sformatf("v%0d_en", i), 32'(en_cnt), 1);
    end

    // Edit loop from SHOW (A=C, B=A, op=1).
    press(17);
    chk("edit_state", 32'(state), 0);
    chk("edit_valid", 32'(res_valid), 0);
    chk("edit_keep", 32'({alu_a, alu_b, alu_ctrl}), 32'({4'hC, 4'hA, 3'd1}));
    press(15);
    press(17);
    press(17);
    en_cnt = 0;
    press(17);
    chk("edit_m", 32'(res_m), 32'h5);
    chk("edit_en", 32'(en_cnt), 1);

    // Priority: clear, enter, digit together in GET_B.
    press(18);
    press(1);
    press(17);
    press(7);
    chk("pri_b", 32'(alu_b), 7);
    saw_op = 0;
    @(negedge hz100);
    pb[18] = 1; pb[17] = 1; pb[3] = 1;
    repeat (4) @(negedge hz100);
    pb = '0;
    repeat (4) @(negedge hz100);
    chk("pri_state", 32'(state), 0);
    chk("pri_regs", 32'({alu_a, alu_b, alu_ctrl, alu_cin}), 0);
    chk("pri_no_op", 32'(saw_op), 0);

    // Latency and held key.
    @(negedge hz100);
    pb[2] = 1;
    @(posedge hz100); #1;
    chk("lat_k", 32'(alu_a), 0);
    @(posedge hz100); #1;
    chk("lat_k1", 32'(alu_a), 0);
    @(posedge hz100); #1;
    chk("lat_k2", 32'(alu_a), 2);
    press(5);
    repeat (50) @(negedge hz100);
    chk("held_once", 32'(alu_a), 5);
    pb[2] = 0;
    repeat (4) @(negedge hz100);
    press(2);
    chk("repress", 32'(alu_a), 2);
    press(16);
    chk("cin_1", 32'(alu_cin), 1);
    press(16);
    chk("cin_0", 32'(alu_cin), 0);

    // Async reset during EXEC.
    press(18);
    press(1);
    press(17);
    press(2);
    press(17);
    @(negedge hz100);
    pb[17] = 1;
    for (int i = 0; i < 10 && state != 3'd3; i++) begin
      @(posedge hz100); #1;
    end
    chk("exec_reached", 32'(state), 3);
    #2;
    reset = 0;
    #1;
    chk("ar_en", 32'(alu_en), 0);
    chk("ar_state", 32'(state), 0);
    chk("ar_regs", 32'({alu_a, alu_b, alu_ctrl, alu_cin}), 0);
    chk("ar_res", 32'({res_m, res_flags, res_valid}), 0);
    pb[5] = 1;
    @(negedge hz100);
    reset = 1;
    repeat (10) @(negedge hz100);
    chk("held_rst_state", 32'(state), 0);
    chk("held_rst_a", 32'(alu_a), 0);
    pb = '0;
    repeat (4) @(negedge hz100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
